// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
// FSM state enum, RISC-V funct3 width/sign codes, and the byte-lane mask
// used to merge sub-word stores into a word read from memory.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched by an access: one lane for bytes, the half picked by
  // off[1] for halfwords, and all four for words (funct3[1:0] = 10 or 11).
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b1111;
    if (f3[1:0] == F3_B[1:0]) begin
      m = 4'b0001 << off;
    end else if (f3[1:0] == F3_H[1:0]) begin
      m = off[1] ? 4'b1100 : 4'b0011;
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
// Load side: extract the addressed byte/half/word from rword and sign- or
// zero-extend it. Store side: replicate wdata across lanes and merge it into
// rword under the lane mask, producing the word to write back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [3:0]  mask;
  logic [31:0] bit_mask;
  logic [31:0] rep;

  // Lane select, extension and store merge.
  always_comb begin
    lane_b   = rword[{off, 3'b000} +: 8];
    lane_h   = off[1] ? rword[31:16] : rword[15:0];
    mask     = lane_mask(funct3, off);
    bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    ldata    = rword;
    rep      = wdata;
    case (funct3[1:0])
      F3_B[1:0]: begin
        ldata = (funct3 == F3_BU) ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        rep   = {4{wdata[7:0]}};
      end
      F3_H[1:0]: begin
        ldata = (funct3 == F3_HU) ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        rep   = {2{wdata[15:0]}};
      end
      default: begin
        ldata = rword;
        rep   = wdata;
      end
    endcase
    mdata = (rword & ~bit_mask) | (rep & bit_mask);
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit, initiator side of the single-port data memory.
// One request at a time: IDLE -> (RD) -> (WR) -> RESP -> IDLE. Sub-word
// stores read-modify-write; word stores write directly; loads read once.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip
// memory and respond with resp_err=1; without it resp_err is tied to 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, holds its payload stable until that edge.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state;
  lsu_state_e  state_nxt;

  logic        op_we;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic [31:0] op_wdata;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic        accept;
  logic        req_word;
  logic        req_mis;

  assign accept   = req_valid && (state == S_IDLE);
  // funct3[1] set means a word access (10 or 11).
  assign req_word = req_funct3[1];

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_err_q;
  assign req_mis  = ((req_funct3[1:0] == F3_H[1:0]) && req_addr[0]) ||
                    (req_word && (req_addr[1:0] != 2'b00));
  assign resp_err = resp_err_q;
`else
  assign req_mis  = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_we     = (state == S_WR);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;

  lsu_align u_align (
    .funct3 (op_f3),
    .off    (op_off),
    .rword  (mem_rdata),
    .wdata  (op_wdata),
    .ldata  (ld_data),
    .mdata  (st_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_mis)                 state_nxt = S_RESP;
          else if (req_we && req_word) state_nxt = S_WR;
          else                         state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = op_we ? S_WR : S_RESP;
      S_WR:    state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, memory address/data and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we        <= 1'b0;
      op_f3        <= 3'b000;
      op_off       <= 2'b00;
      op_wdata     <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        op_we        <= req_we;
        op_f3        <= req_funct3;
        op_off       <= req_addr[1:0];
        op_wdata     <= req_wdata;
        resp_rdata_q <= 32'h0;
        // A trapped access never touches the memory port.
        if (!req_mis) begin
          mem_addr_q <= {req_addr[31:2], 2'b00};
          if (req_we && req_word) mem_wdata_q <= req_wdata;
        end
      end
      if (state == S_RD) begin
        if (op_we) mem_wdata_q  <= st_data;
        else       resp_rdata_q <= ld_data;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Error flag, captured at acceptance and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      resp_err_q <= 1'b0;
    else if (accept) resp_err_q <= req_mis;
  end
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu with a word memory and a byte-level
// reference model of memory contents and response rules.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: 256 words at 0x2000, combinational read, write on posedge.
  logic [31:0] mem [0:255];
  logic        mem_clear;
  logic        mem_hit;
  assign mem_hit   = (mem_addr[31:10] == 22'h8) && (mem_addr[1:0] == 2'b00);
  assign mem_rdata = mem_hit ? mem[mem_addr[9:2]] : 32'hdeadbeef;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_we && mem_hit) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Reference model: byte array mirroring memory from 0x2000.
  logic [7:0]  ref_b [0:1023];
  logic [31:0] exp_q [$];

  // Expected outcome of one access; applies stores to the reference bytes.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] e_rd, output logic e_err,
                       output int e_lat, output int e_we);
    int size;
    int off;
    int base;
    logic [31:0] v;
    bit mis;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(addr - 32'h2000);
    mis  = TRAP && ((off % size) != 0);
    base = off - (off % size);
    e_rd  = 32'h0;
    e_err = mis;
    e_we  = 0;
    if (mis) begin
      e_lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_b[base + i] = wd[8*i +: 8];
      e_we  = 1;
      e_lat = (size == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_b[base + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
      e_rd  = v;
      e_lat = 2;
    end
  endtask

  // Observations of the last driven access.
  logic        o_rdy;
  logic [31:0] o_rd;
  logic        o_err;
  int          o_lat;
  int          o_we;
  logic [31:0] o_wr;
  logic [31:0] e_rd;
  logic        e_err;
  int          e_lat;
  int          e_we;

  // Driver: issue one request at a negedge, follow it to its response and
  // return at the negedge of the following idle cycle.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    o_rdy      = req_ready;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    o_lat = -1; o_we = 0; o_wr = 32'h0; o_rd = 32'h0; o_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_we) begin o_we++; o_wr = mem_wdata; end
      if (resp_valid) begin o_lat = n; o_rd = resp_rdata; o_err = resp_err; break; end
    end
    @(negedge clk);
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    model(we, f3, addr, wd, e_rd, e_err, e_lat, e_we);
    do_op(we, f3, addr, wd);
  endtask

  task automatic test_reset();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
  endtask

  task automatic test_byte_loads();
    run(1'b1, 3'b010, 32'h200c, 32'hf00ff00f);
    n_cmp++; if (o_lat !== 2 || o_we !== 1) begin n_bad++; $display("FAIL sw_200c: lat %0d we %0d want 2 1", o_lat, o_we); end
    run(1'b0, 3'b000, 32'h200c, 32'h0);
    n_cmp++; if (o_rd !== 32'h0000000f) begin n_bad++; $display("FAIL lb_200c: got %h want 0000000f", o_rd); end
    n_cmp++; if (o_lat !== 2) begin n_bad++; $display("FAIL lb_latency: got %0d want 2", o_lat); end
    run(1'b0, 3'b000, 32'h200d, 32'h0);
    n_cmp++; if (o_rd !== 32'hfffffff0) begin n_bad++; $display("FAIL lb_200d: got %h want fffffff0", o_rd); end
    run(1'b0, 3'b100, 32'h200f, 32'h0);
    n_cmp++; if (o_rd !== 32'h000000f0) begin n_bad++; $display("FAIL lbu_200f: got %h want 000000f0", o_rd); end
  endtask

  task automatic test_subword_store();
    run(1'b1, 3'b010, 32'h2000, 32'h000000ff);
    run(1'b1, 3'b000, 32'h2001, 32'h000000aa);
    n_cmp++; if (o_lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d want 3", o_lat); end
    n_cmp++; if (o_we !== 1) begin n_bad++; $display("FAIL sb_we_cycles: got %0d want 1", o_we); end
    n_cmp++; if (o_wr !== 32'h0000aaff) begin n_bad++; $display("FAIL sb_merge: got %h want 0000aaff", o_wr); end
    n_cmp++; if (o_rd !== 32'h0) begin n_bad++; $display("FAIL sb_rdata: got %h want 0", o_rd); end
    run(1'b0, 3'b010, 32'h2000, 32'h0);
    n_cmp++; if (o_rd !== 32'h0000aaff) begin n_bad++; $display("FAIL lw_2000: got %h want 0000aaff", o_rd); end
  endtask

  task automatic test_word_store();
    run(1'b1, 3'b010, 32'h2004, 32'h12345678);
    n_cmp++; if (o_lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", o_lat); end
    n_cmp++; if (o_we !== 1 || o_wr !== 32'h12345678) begin n_bad++; $display("FAIL sw_write: we %0d data %h want 1 12345678", o_we, o_wr); end
    run(1'b0, 3'b001, 32'h2006, 32'h0);
    n_cmp++; if (o_rd !== 32'h00001234) begin n_bad++; $display("FAIL lh_2006: got %h want 00001234", o_rd); end
    run(1'b0, 3'b101, 32'h2004, 32'h0);
    n_cmp++; if (o_rd !== 32'h00005678) begin n_bad++; $display("FAIL lhu_2004: got %h want 00005678", o_rd); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h200d; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    held = resp_rdata;
    n_cmp++; if (resp_valid !== 1'b1 || held !== 32'hfffffff0) begin n_bad++; $display("FAIL stall_first: valid %b data %h want 1 fffffff0", resp_valid, held); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold: valid %b data %h ready %b we %b want 1 %h 0 0", resp_valid, resp_rdata, req_ready, mem_we, held);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: ready %b valid %b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_reset_mid();
    run(1'b1, 3'b010, 32'h2008, 32'h11223344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h200a; req_wdata = 32'h0000beef;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rmid_in_wr: mem_we %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rmid_outputs: we %b rv %b err %b rdy %b addr %h wd %h rd %h want reset values",
               mem_we, resp_valid, resp_err, req_ready, mem_addr, mem_wdata, resp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 3'b010, 32'h2008, 32'h0);
    n_cmp++; if (o_rd !== 32'h11223344) begin n_bad++; $display("FAIL rmid_word: got %h want 11223344", o_rd); end
  endtask

  task automatic test_misalign();
    run(1'b0, 3'b010, 32'h2002, 32'h0);
    if (TRAP) begin
      n_cmp++; if (o_err !== 1'b1 || o_lat !== 1) begin n_bad++; $display("FAIL mis_trap: err %b lat %0d want 1 1", o_err, o_lat); end
      n_cmp++; if (o_we !== 0 || o_rd !== 32'h0) begin n_bad++; $display("FAIL mis_noacc: we %0d rd %h want 0 0", o_we, o_rd); end
    end else begin
      n_cmp++; if (o_err !== 1'b0 || o_lat !== 2) begin n_bad++; $display("FAIL mis_plain: err %b lat %0d want 0 2", o_err, o_lat); end
      n_cmp++; if (o_rd !== 32'h0000aaff) begin n_bad++; $display("FAIL mis_word: got %h want 0000aaff", o_rd); end
    end
    run(1'b1, 3'b001, 32'h2011, 32'h0000c3c3);
    n_cmp++; if (o_we !== e_we || o_err !== e_err) begin n_bad++; $display("FAIL mis_sh: we %0d err %b want %0d %b", o_we, o_err, e_we, e_err); end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] want;
    for (int t = 0; t < 60; t++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h2000 + 32'($urandom_range(0, 63));
      wd   = $urandom;
      run(we, f3, addr, wd);
      exp_q.push_back(e_rd);
      want = exp_q.pop_front();
      n_cmp++; if (o_rd !== want) begin n_bad++; $display("FAIL rnd_rdata: t %0d we %b f3 %0d addr %h got %h want %h", t, we, f3, addr, o_rd, want); end
      n_cmp++; if (o_lat !== e_lat) begin n_bad++; $display("FAIL rnd_latency: t %0d got %0d want %0d", t, o_lat, e_lat); end
      n_cmp++; if (o_we !== e_we || o_err !== e_err) begin n_bad++; $display("FAIL rnd_we_err: t %0d we %0d err %b want %0d %b", t, o_we, o_err, e_we, e_err); end
      n_cmp++; if (o_rdy !== 1'b1) begin n_bad++; $display("FAIL rnd_ready: t %0d got %b want 1", t, o_rdy); end
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
    #2;
    test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mem_clear = 1'b0;
    @(negedge clk);
    test_byte_loads();
    test_subword_store();
    test_word_store();
    test_stall();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
